data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-side memory responder for the single-cycle core: word RAM plus a small I/O page
// (cycle counter, TX FIFO, status). Optional counter gated by DMEM_CYCLE_COUNTER_EN.
module data_mem_responder #(
  parameter int unsigned AW         = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW        = PW + 1;
  localparam int unsigned RAM_WORDS = 1 << AW;

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_TXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;

  logic          io_sel;
  logic [7:0]    off;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          tx_we;
  logic          status_we;

  logic [31:0]   mem [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          ovf_set;

  logic [31:0]   cycle_rd;
  logic [31:0]   status_word;
  logic [31:0]   io_rd;

  // Address decode: the top 24 bits all-ones select the I/O page
  assign io_sel    = (a[31:8] == 24'hFFFFFF);
  assign off       = a[7:0];
  assign ram_idx   = a[AW+1:2];
  assign ram_we    = we && !io_sel;
  assign tx_we     = we && io_sel && (off == OFF_TXDATA);
  assign status_we = we && io_sel && (off == OFF_STATUS);

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot a full-FIFO push needs
  assign push      = tx_we && (!full || pop);
  assign ovf_set   = tx_we && full && !pop;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= wd;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (status_we) begin
      ovf <= 1'b0;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic        cycle_we;
  logic [31:0] cycle_cnt;

  assign cycle_we = we && io_sel && (off == OFF_CYCLE);

  // A CYCLE write overrides the free-running increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (cycle_we) begin
      cycle_cnt <= wd;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign cycle_rd = cycle_cnt;
`else
  assign cycle_rd = '0;
`endif

  assign status_word = {21'b0, ovf, full, empty, 8'(count)};

  always_comb begin
    io_rd = '0;
    case (off)
      OFF_CYCLE:  io_rd = cycle_rd;
      OFF_STATUS: io_rd = status_word;
      default:    io_rd = '0;
    endcase
  end

  // Read-before-write: rd reflects contents ahead of this cycle's edge
  assign rd = io_sel ? io_rd : mem[ram_idx];

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder: behavioural model of RAM, I/O page and
// FIFO occupancy; a separate monitor checks drained words in order.
module tb_data_mem_responder;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] A_CYCLE  = 32'hFFFFFF00;
  localparam logic [31:0] A_TXDATA = 32'hFFFFFF04;
  localparam logic [31:0] A_STATUS = 32'hFFFFFF08;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int tests;
  int fails;

  // Reference model state
  logic [31:0] ref_mem [1 << AW];
  bit          ref_known [1 << AW];
  logic [31:0] exp_q [$];
  int          occ;
  bit          ref_ovf;
  logic [31:0] ref_cnt;

  data_mem_responder #(.AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .wd        (wd),
    .we        (we),
    .rd        (rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] addr, output bit known);
    logic [31:0] r;
    int idx;
    known = 1'b1;
    r = '0;
    if (addr[31:8] == 24'hFFFFFF) begin
      if (addr[7:0] == 8'h00) begin
`ifdef DMEM_CYCLE_COUNTER_EN
        r = ref_cnt;
`else
        r = '0;
`endif
      end else if (addr[7:0] == 8'h08) begin
        r = {21'b0, ref_ovf, occ == int'(DEPTH), occ == 0, 8'(occ)};
      end
    end else begin
      idx = int'(addr[AW+1:2]);
      known = ref_known[idx];
      r = ref_mem[idx];
    end
    return r;
  endfunction

  // One clock cycle: drive at posedge+1, check combinational outputs, then apply the edge to the model
  task automatic step(input logic [31:0] addr, input logic [31:0] data, input logic w, input logic rdy);
    logic [31:0] e;
    bit known;
    bit io;
    bit popping;
    int idx;
    a = addr; wd = data; we = w; out_ready = rdy;
    #1;
    e = model_rd(addr, known);
    if (known) check("rd", rd, e);
    check("out_valid", 32'(out_valid), 32'(occ != 0));
    @(posedge clk);
    io = (addr[31:8] == 24'hFFFFFF);
    popping = (occ != 0) && rdy;
    if (w && !io) begin
      idx = int'(addr[AW+1:2]);
      ref_mem[idx] = data;
      ref_known[idx] = 1'b1;
    end
    if (w && io && addr[7:0] == 8'h04) begin
      if (occ < int'(DEPTH) || popping) begin
        exp_q.push_back(data);
        occ++;
      end else begin
        ref_ovf = 1'b1;
      end
    end
    if (w && io && addr[7:0] == 8'h08) ref_ovf = 1'b0;
    if (popping) occ--;
    if (w && io && addr[7:0] == 8'h00) ref_cnt = data;
    else ref_cnt = ref_cnt + 32'd1;
    #1;
  endtask

  // Combinational peek against a fixed expectation, no clock advance
  task automatic peek(input string name, input logic [31:0] addr, input logic [31:0] exp);
    a = addr; we = 1'b0;
    #1;
    check(name, rd, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    occ = 0;
    ref_ovf = 1'b0;
    ref_cnt = '0;
  endtask

  // Monitor: compares FIFO head with scoreboard, consumes it on handshake
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", out_data, 32'hxxxxxxxx);
      end else begin
        check("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] addr;
    tests = 0; fails = 0;
    for (int i = 0; i < (1 << AW); i++) ref_known[i] = 1'b0;
    model_reset();
    reset = 1'b1; a = '0; wd = '0; we = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    reset = 1'b0;

    // Counter reads 0 in the first cycle after release, then 1
`ifdef DMEM_CYCLE_COUNTER_EN
    peek("cycle_first", A_CYCLE, 32'd0);
    step(A_CYCLE, 32'd0, 1'b0, 1'b0);
    peek("cycle_second", A_CYCLE, 32'd1);
`else
    peek("cycle_first", A_CYCLE, 32'd0);
    step(A_CYCLE, 32'd0, 1'b0, 1'b0);
    peek("cycle_second", A_CYCLE, 32'd0);
`endif
    peek("status_reset", A_STATUS, 32'h100);

    for (int i = 0; i < (1 << AW); i++) step(32'(i * 4), $urandom, 1'b1, 1'b0);

    // RAM write/read and aliasing
    step(32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
    peek("ram_0x10", 32'h10, 32'hDEADBEEF);
    peek("ram_0x13", 32'h13, 32'hDEADBEEF);
    peek("ram_alias", 32'h110, 32'hDEADBEEF);

    // Read-before-write
    step(32'h20, 32'h5, 1'b1, 1'b0);
    a = 32'h20; wd = 32'h1; we = 1'b1;
    #1;
    check("rbw_old", rd, 32'h5);
    step(32'h20, 32'h1, 1'b1, 1'b0);
    peek("rbw_new", 32'h20, 32'h1);

    // Fill, overflow, clear
    for (int i = 1; i <= 4; i++) step(A_TXDATA, 32'(i), 1'b1, 1'b0);
    peek("status_full", A_STATUS, 32'h204);
    check("head_one", out_data, 32'd1);
    step(A_TXDATA, 32'd5, 1'b1, 1'b0);
    peek("status_ovf", A_STATUS, 32'h604);
    step(A_STATUS, 32'd0, 1'b1, 1'b0);
    peek("status_clr", A_STATUS, 32'h204);

    // Push while full with simultaneous pop, then drain
    step(A_TXDATA, 32'd9, 1'b1, 1'b1);
    peek("status_pushpop", A_STATUS, 32'h204);
    for (int i = 0; i < 4; i++) step(32'h0, 32'd0, 1'b0, 1'b1);
    peek("status_drained", A_STATUS, 32'h100);
    check("drained_valid", 32'(out_valid), 32'd0);

    // Counter wrap
    step(A_CYCLE, 32'hFFFFFFFE, 1'b1, 1'b0);
`ifdef DMEM_CYCLE_COUNTER_EN
    peek("cycle_load", A_CYCLE, 32'hFFFFFFFE);
    step(A_CYCLE, 32'd0, 1'b0, 1'b0);
    peek("cycle_max", A_CYCLE, 32'hFFFFFFFF);
    step(A_CYCLE, 32'd0, 1'b0, 1'b0);
    peek("cycle_wrap", A_CYCLE, 32'h0);
`else
    peek("cycle_load", A_CYCLE, 32'h0);
    step(A_CYCLE, 32'd0, 1'b0, 1'b0);
    peek("cycle_max", A_CYCLE, 32'h0);
`endif

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step(A_TXDATA, $urandom, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", out_data, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    peek("status_after_rst", A_STATUS, 32'h100);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: addr = $urandom;
        3:       addr = A_CYCLE;
        4:       addr = A_TXDATA;
        5:       addr = ($urandom_range(0, 3) == 0) ? A_STATUS : A_TXDATA;
        default: addr = {24'hFFFFFF, 8'($urandom_range(9, 255))};
      endcase
      step(addr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
